// File: rtl/display_scan_driver.sv
// Binary-to-BCD display feeder: a serial double-dabble converter plus a digit scanner with leading-zero blanking.
// Optional raw-hex display path is enabled by defining DISPLAY_HEX_MODE_EN.
module display_scan_driver #(
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
`ifdef DISPLAY_HEX_MODE_EN
    input  logic                  hex_mode,
`endif
    output logic                  busy,
    output logic [3:0]            digit_nibble,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [IDX_W-1:0]      scan_idx
);

    // state | meaning
    // IDLE  | waiting for load; display register scanning the last result
    // SHIFT | one double-dabble iteration per cycle, DATA_W cycles
    // LATCH | accumulator copied into the display register

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PS_W  = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         bin_q;
    logic [BCD_W-1:0]          acc_q;
    logic [BCD_W-1:0]          disp_q;
    logic [BCD_W-1:0]          bcd_adj;
    logic [BCD_W+DATA_W-1:0]   shifted;
    logic [CNT_W-1:0]          iter_q;
    logic [PS_W-1:0]           ps_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_DIGITS-1:0]     digit_on;
    logic                      any_nz;
    logic                      hex_req;
    logic                      start_bcd;
    logic                      start_hex;
    logic                      do_shift;
    logic                      do_latch;
    logic                      last_iter;

`ifdef DISPLAY_HEX_MODE_EN
    assign hex_req = hex_mode;
`else
    assign hex_req = 1'b0;
`endif

    assign last_iter = (iter_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_bcd = 1'b0;
        start_hex = 1'b0;
        do_shift  = 1'b0;
        do_latch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (hex_req) begin
                        start_hex = 1'b1;
                        state_d   = LATCH;
                    end else begin
                        start_bcd = 1'b1;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (last_iter) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                do_latch = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Add-3 correction on every nibble in parallel, then shift the joint register.
    always_comb begin
        bcd_adj = acc_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            acc_q  <= '0;
            iter_q <= '0;
            disp_q <= '0;
        end else begin
            if (start_bcd) begin
                bin_q  <= value;
                acc_q  <= '0;
                iter_q <= '0;
            end else if (start_hex) begin
                acc_q <= BCD_W'(value);
            end else if (do_shift) begin
                acc_q  <= shifted[BCD_W+DATA_W-1:DATA_W];
                bin_q  <= shifted[DATA_W-1:0];
                iter_q <= iter_q + CNT_W'(1);
            end
            if (do_latch) begin
                disp_q <= acc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q  <= '0;
            idx_q <= '0;
        end else if (ps_q == PS_W'(REFRESH_DIV - 1)) begin
            ps_q  <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // A digit stays lit if it or any more-significant digit is non-zero; digit 0 always lit.
    always_comb begin
        any_nz   = 1'b0;
        digit_on = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            any_nz      = any_nz | (disp_q[4*k +: 4] != 4'd0);
            digit_on[k] = any_nz;
        end
        digit_on[0] = 1'b1;
    end

    always_comb begin
        digit_nibble = 4'd0;
        digit_en     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit_nibble = disp_q[4*k +: 4];
                digit_en[k]  = digit_on[k];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign scan_idx = idx_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver (DATA_W=8, NUM_DIGITS=4, REFRESH_DIV=4).
// Raw-hex scenario runs only when DISPLAY_HEX_MODE_EN is defined.
module tb_display_scan_driver;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] value;
`ifdef DISPLAY_HEX_MODE_EN
    logic       hex_mode;
`endif
    logic       busy;
    logic [3:0] digit_nibble;
    logic [3:0] digit_en;
    logic [1:0] scan_idx;

    int checks;
    int failures;

    display_scan_driver #(
        .DATA_W(8),
        .NUM_DIGITS(4),
        .REFRESH_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .value(value),
`ifdef DISPLAY_HEX_MODE_EN
        .hex_mode(hex_mode),
`endif
        .busy(busy),
        .digit_nibble(digit_nibble),
        .digit_en(digit_en),
        .scan_idx(scan_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
`ifdef DISPLAY_HEX_MODE_EN
        hex_mode = 1'b0;
`endif
        @(negedge clk);
        load = 1'b0;
    endtask

`ifdef DISPLAY_HEX_MODE_EN
    task automatic do_load_hex(input logic [7:0] v);
        @(negedge clk);
        value    = v;
        load     = 1'b1;
        hex_mode = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        hex_mode = 1'b0;
    endtask
`endif

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic goto_idx(input int k);
        int n;
        n = 0;
        while (int'(scan_idx) != k && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL goto_idx: scan_idx=%0d never reached %0d", scan_idx, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (scan_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_idx: got %0d want 0", scan_idx);
        end
        checks++;
        if (digit_nibble !== 4'd0) begin
            failures++;
            $display("FAIL reset_nibble: got %h want 0", digit_nibble);
        end
        checks++;
        if (digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL reset_en: got %b want 0001", digit_en);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_idx;
        logic [3:0] exp_en;
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin
            exp_idx = 2'((j / 4) % 4);
            exp_en  = (exp_idx == 2'd0) ? 4'b0001 : 4'b0000;
            checks++;
            if (scan_idx !== exp_idx) begin
                failures++;
                $display("FAIL scan_idx[%0d]: got %0d want %0d", j, scan_idx, exp_idx);
            end
            checks++;
            if (digit_nibble !== 4'd0 || digit_en !== exp_en) begin
                failures++;
                $display("FAIL scan_out[%0d]: got nib=%h en=%b want nib=0 en=%b", j, digit_nibble, digit_en, exp_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_conv_255();
        int n;
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'd5, 4'd5, 4'd2, 4'd0};
        en_e  = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
        do_load(8'd255);
        wait_idle(n);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL busy_len_255: got %0d cycles want 9", n);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_255[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask

    task automatic test_conv_100();
        int n;
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'd0, 4'd0, 4'd1, 4'd0};
        en_e  = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
        do_load(8'd100);
        wait_idle(n);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL busy_len_100: got %0d cycles want 9", n);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_100[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask

    task automatic test_load_while_busy();
        int n;
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'd7, 4'd0, 4'd0, 4'd0};
        en_e  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        do_load(8'd7);
        @(negedge clk);
        @(negedge clk);
        value = 8'd200;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL busy_tail_ignore: got %0d cycles want 6", n);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_7[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask

    task automatic test_load_on_latch();
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'd3, 4'd0, 4'd0, 4'd0};
        en_e  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        do_load(8'd3);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_latch: got %b want 1", busy);
        end
        value = 8'd200;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL latch_load_ignored: busy got %b want 0", busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL latch_load_stays_idle: busy got %b want 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_3[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask

    task automatic test_reset_mid_conversion();
        int n;
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'd2, 4'd4, 4'd0, 4'd0};
        en_e  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        do_load(8'd99);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || scan_idx !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b idx=%0d want busy=0 idx=0", busy, scan_idx);
        end
        checks++;
        if (digit_nibble !== 4'd0 || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset_disp: got nib=%h en=%b want nib=0 en=0001", digit_nibble, digit_en);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || digit_nibble !== 4'd0) begin
            failures++;
            $display("FAIL reset_discard: got busy=%b nib=%h want busy=0 nib=0", busy, digit_nibble);
        end
        do_load(8'd42);
        wait_idle(n);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL busy_len_42: got %0d cycles want 9", n);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_42[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask

`ifdef DISPLAY_HEX_MODE_EN
    task automatic test_hex_mode();
        int n;
        logic [3:0] nib_e [4];
        logic [3:0] en_e [4];
        nib_e = '{4'h7, 4'hA, 4'h0, 4'h0};
        en_e  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        do_load_hex(8'hA7);
        wait_idle(n);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL busy_len_hex: got %0d cycles want 1", n);
        end
        for (int k = 0; k < 4; k++) begin
            goto_idx(k);
            checks++;
            if (digit_nibble !== nib_e[k] || digit_en !== en_e[k]) begin
                failures++;
                $display("FAIL digit_hex[%0d]: got nib=%h en=%b want nib=%h en=%b", k, digit_nibble, digit_en, nib_e[k], en_e[k]);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        load     = 1'b0;
        value    = 8'd0;
`ifdef DISPLAY_HEX_MODE_EN
        hex_mode = 1'b0;
`endif
        test_reset();
        test_scan();
        test_conv_255();
        test_conv_100();
        test_load_while_busy();
        test_load_on_latch();
        test_reset_mid_conversion();
`ifdef DISPLAY_HEX_MODE_EN
        test_hex_mode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
